// File: rtl/bram_wr_ctrl_gen_if.sv
// Write-side bus of the line-buffer BRAM controller: the DMA beat stream in,
// BRAM write port out.
//
// Handshake: a beat transfers on a rising edge where i_wr_vld and o_wr_rdy
// are both high. The source may raise i_wr_vld at any time and must hold the
// beat until it transfers. o_wr_rdy depends only on controller state, never
// on i_wr_vld.
interface bram_wr_ctrl_gen_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int BUF_NUM    = 16
);
  logic                  i_wr_vld;
  logic                  o_wr_rdy;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_bram_en;
  logic [BUF_NUM-1:0]    o_bram_cs;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic [DATA_WIDTH-1:0] o_bram_wdata;

  // Source and observer of the beat stream / BRAM port.
  modport master (
    output i_wr_vld, i_wr_data,
    input  o_wr_rdy, o_bram_en, o_bram_cs, o_bram_addr, o_bram_wdata
  );

  // The controller itself.
  modport slave (
    input  i_wr_vld, i_wr_data,
    output o_wr_rdy, o_bram_en, o_bram_cs, o_bram_addr, o_bram_wdata
  );
endinterface

// File: rtl/bram_wr_ctrl_gen.sv
// Ping-pong write controller for the CNN line-buffer bank. Beats are steered
// to one of BUF_NUM buffers; an optional prime pass fills all buffers, then
// the lower and upper halves refill alternately, each half separated by a
// WAIT that the conv engine releases with i_restart.
module bram_wr_ctrl_gen #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int BUF_NUM    = 16,
  parameter int BEAT_BITS  = 4,
  parameter int BURST_BITS = 2,
  parameter int MODE_BITS  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_cfg_prime,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base,
  input  logic                  i_end,
  input  logic                  i_restart,
  bram_wr_ctrl_gen_if.slave     bus,
  output logic                  o_half_sel,
  output logic                  o_half_done,
  output logic                  o_prime_done,
  output logic                  o_busy,
  output logic [2:0]            o_state_dbg
);

  localparam int BI_W  = $clog2(BUF_NUM);
  localparam int OFF_W = MODE_BITS + BURST_BITS + BEAT_BITS;

  localparam logic [BI_W-1:0]       IDX_HALF  = BI_W'(BUF_NUM / 2);
  localparam logic [BI_W-1:0]       IDX_LO_LAST = BI_W'(BUF_NUM / 2 - 1);
  localparam logic [BI_W-1:0]       IDX_LAST  = BI_W'(BUF_NUM - 1);
  localparam logic [BEAT_BITS-1:0]  BEAT_MAX  = {BEAT_BITS{1'b1}};
  localparam logic [BURST_BITS-1:0] BURST_MAX = {BURST_BITS{1'b1}};
  localparam logic [BUF_NUM-1:0]    CS_ONE    = BUF_NUM'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRIME   = 3'd1,
    S_FILL_LO = 3'd2,
    S_FILL_HI = 3'd3,
    S_WAIT    = 3'd4,
    S_END     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  state_t                next_q, next_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [MODE_BITS-1:0]  mode_q, mode_d;
  logic [BI_W-1:0]       buf_q, buf_d;
  logic [BURST_BITS-1:0] burst_q, burst_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;

  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  half_sel_q, half_sel_d;
  logic                  half_done_q, half_done_d;
  logic                  prime_done_q, prime_done_d;
  logic                  en_q, en_d;
  logic [BUF_NUM-1:0]    cs_q, cs_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  accept;
  logic                  last_buf;
  logic                  pass_end;
  logic [ADDR_WIDTH-1:0] offset;

  // Next-state, counter and write-strobe computation.
  always_comb begin
    state_d      = state_q;
    next_d       = next_q;
    base_d       = base_q;
    mode_d       = mode_q;
    buf_d        = buf_q;
    burst_d      = burst_q;
    beat_d       = beat_q;

    accept   = bus.i_wr_vld && rdy_q;
    last_buf = (state_q == S_FILL_LO) ? (buf_q == IDX_LO_LAST) : (buf_q == IDX_LAST);
    pass_end = accept && (beat_q == BEAT_MAX) && (burst_q == BURST_MAX) && last_buf;

    offset              = '0;
    offset[OFF_W-1:0]   = {mode_q, burst_q, beat_q};

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d  = i_cfg_base;
          mode_d  = '0;
          buf_d   = '0;
          burst_d = '0;
          beat_d  = '0;
          state_d = i_cfg_prime ? S_PRIME : S_FILL_LO;
        end
      end
      S_PRIME, S_FILL_LO, S_FILL_HI: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_MAX) begin
            burst_d = burst_q + 1'b1;
            if (burst_q == BURST_MAX) buf_d = buf_q + 1'b1;
          end
          if (pass_end) begin
            state_d = S_WAIT;
            if (state_q == S_FILL_LO) begin
              next_d = S_FILL_HI;
            end else begin
              // Prime and upper-half passes both close a page.
              next_d = S_FILL_LO;
              mode_d = mode_q + 1'b1;
            end
          end
        end
      end
      S_WAIT: begin
        if (i_restart) begin
          state_d = next_q;
          buf_d   = (next_q == S_FILL_HI) ? IDX_HALF : '0;
          burst_d = '0;
          beat_d  = '0;
        end
      end
      S_END: begin
        if (i_restart) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle restart.
    if ((state_q != S_IDLE) && i_end) begin
      state_d = S_END;
      buf_d   = '0;
      burst_d = '0;
      beat_d  = '0;
    end

    // A beat accepted this cycle is written on the next one, whatever the state.
    en_d    = accept;
    cs_d    = accept ? (CS_ONE << buf_q) : '0;
    addr_d  = accept ? (base_q + offset) : addr_q;
    wdata_d = accept ? bus.i_wr_data : wdata_q;

    half_done_d  = pass_end && ((state_q == S_FILL_LO) || (state_q == S_FILL_HI));
    prime_done_d = pass_end && (state_q == S_PRIME);

    rdy_d  = (state_d == S_PRIME) || (state_d == S_FILL_LO) || (state_d == S_FILL_HI);
    busy_d = (state_d != S_IDLE);

    // WAIT keeps the half of the pass that led into it.
    case (state_d)
      S_FILL_HI: half_sel_d = 1'b1;
      S_WAIT:    half_sel_d = half_sel_q;
      default:   half_sel_d = 1'b0;
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      next_q       <= S_IDLE;
      base_q       <= '0;
      mode_q       <= '0;
      buf_q        <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      half_sel_q   <= 1'b0;
      half_done_q  <= 1'b0;
      prime_done_q <= 1'b0;
      en_q         <= 1'b0;
      cs_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      next_q       <= next_d;
      base_q       <= base_d;
      mode_q       <= mode_d;
      buf_q        <= buf_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      half_sel_q   <= half_sel_d;
      half_done_q  <= half_done_d;
      prime_done_q <= prime_done_d;
      en_q         <= en_d;
      cs_q         <= cs_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.o_wr_rdy     = rdy_q;
  assign bus.o_bram_en    = en_q;
  assign bus.o_bram_cs    = cs_q;
  assign bus.o_bram_addr  = addr_q;
  assign bus.o_bram_wdata = wdata_q;
  assign o_half_sel       = half_sel_q;
  assign o_half_done      = half_done_q;
  assign o_prime_done     = prime_done_q;
  assign o_busy           = busy_q;
  assign o_state_dbg      = state_q;

endmodule

// File: doc/bram_wr_ctrl_gen.md
Name: bram_wr_ctrl_gen

Overview:
Parametrised write-side BRAM controller for the CNN line-buffer bank. It accepts beats from the DMA read stream with a valid/ready handshake. Each beat is steered to one of BUF_NUM line buffers through a one-hot chip select and an address of the form base + {mode, burst, beat}. Filling follows a ping-pong scheme: an optional prime pass loads all buffers, then the lower and upper halves refill alternately. Between halves the block stalls for an i_restart from the conv engine.

Parameters:
ADDR_WIDTH, 14, BRAM address width; must be >= MODE_BITS+BURST_BITS+BEAT_BITS.
DATA_WIDTH, 64, write data width.
BUF_NUM, 16, number of line buffers; power of 2, >= 2.
BEAT_BITS, 4, beats per burst = 2^BEAT_BITS.
BURST_BITS, 2, bursts per buffer fill = 2^BURST_BITS.
MODE_BITS, 2, address page (mode) counter width.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_start  in  1  start pulse; sampled only in IDLE
i_cfg_prime  in  1  latched at start; 1 = run PRIME pass first
i_cfg_base  in  ADDR_WIDTH  base address; latched at start
i_end  in  1  abort/finish request
i_restart  in  1  resume from WAIT, or return from END to IDLE
i_wr_vld  in  1  input beat valid
o_wr_rdy  out  1  input beat ready
i_wr_data  in  DATA_WIDTH  input beat data
o_bram_en  out  1  BRAM write enable
o_bram_cs  out  BUF_NUM  one-hot buffer select
o_bram_addr  out  ADDR_WIDTH  BRAM write address
o_bram_wdata  out  DATA_WIDTH  BRAM write data
o_half_sel  out  1  half being written: 0 = lower, 1 = upper
o_half_done  out  1  one-cycle pulse when a FILL half completes
o_prime_done  out  1  one-cycle pulse when PRIME completes
o_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset state: state = IDLE; all counters, mode and latched config = 0.
- Reset values of outputs: all outputs 0.
- States and transitions:
  - IDLE: on i_start, latch config, mode=0, buf_idx=0. Go to PRIME if i_cfg_prime, else FILL_LO.
  - PRIME: buf_idx runs 0..BUF_NUM-1.
  - FILL_LO: buf_idx runs 0..BUF_NUM/2-1.
  - FILL_HI: buf_idx runs BUF_NUM/2..BUF_NUM-1.
  - WAIT: o_wr_rdy=0; on i_restart go to the stored next state.
  - END: o_wr_rdy=0; on i_restart go to IDLE.
- o_wr_rdy = 1 only in PRIME, FILL_LO and FILL_HI. A beat is accepted when i_wr_vld && o_wr_rdy.
- Write latency: 1 cycle. The cycle after acceptance, o_bram_en=1, o_bram_cs = 1<<buf_idx, o_bram_wdata = data of the accepted beat, and o_bram_addr = (i_cfg_base + {mode,burst_cnt,beat_cnt}) truncated to ADDR_WIDTH (zero-extended concatenation). Otherwise o_bram_en=0 and o_bram_cs=0; addr and wdata hold.
- Counters advance only on accepted beats; gaps in i_wr_vld freeze them.
  - beat_cnt wraps at 2^BEAT_BITS; the wrap increments burst_cnt.
  - burst_cnt wraps at 2^BURST_BITS; the wrap increments buf_idx.
- End of pass (last beat of the last buffer in the pass):
  - PRIME: o_prime_done pulses in the same cycle as the final write strobe. mode increments. Go to WAIT with next = FILL_LO.
  - FILL_LO: o_half_done pulses with the final strobe. Go to WAIT with next = FILL_HI.
  - FILL_HI: o_half_done pulses with the final strobe. mode increments. Go to WAIT with next = FILL_LO.
  - mode wraps modulo 2^MODE_BITS.
- The final beat's strobe is still issued after leaving the fill state.
- o_half_sel is 1 in FILL_HI and in WAIT when next = FILL_LO after HI; it is 0 otherwise. Registered.
- i_end in any non-IDLE state:
  - Next state is END.
  - beat, burst and buf counters clear.
  - An already-accepted beat still produces its strobe the following cycle.
  - i_end has priority over i_restart in the same cycle.
- i_start outside IDLE is ignored. i_restart in PRIME/FILL/IDLE is ignored.

Test Plan:
- Bench config for all scenarios: ADDR_WIDTH=8, BUF_NUM=4, BEAT_BITS=2, BURST_BITS=1, MODE_BITS=2 (8 beats per buffer).
- Reset: hold i_rst 2 cycles mid-traffic -> all outputs 0 the next cycle, state IDLE, o_wr_rdy=0.
- Prime pass: i_start with prime=1, base=0x10, then 32 continuous beats -> cs 0001 with addr 0x10..0x17, then 0010, 0100, 1000 (each buffer repeats 0x10..0x17). o_prime_done coincides with the 32nd strobe; o_wr_rdy=0 afterwards.
- Ping-pong: i_restart, then 16 beats -> cs 0001/0010 with addr 0x18..0x1F and o_half_done pulse. i_restart, then 16 beats -> cs 0100/1000 with addr 0x18..0x1F and o_half_sel=1. Next FILL_LO uses addr 0x20..0x27.
- Backpressure: toggle i_wr_vld 1/0 every cycle -> exactly one strobe per accepted beat, no address skips or repeats, wdata matches beat order.
- Abort: i_end and i_restart together during beat 3 of FILL_HI -> END, o_wr_rdy=0, pending strobe issued once. i_restart -> IDLE with o_busy=0. New i_start restarts at mode 0, addr = base.
- Wrap: base=0xFC, prime=0, five FILL_LO/HI cycles -> mode sequence 0,1,2,3,0 and addresses wrap mod 256 (0xFC+0x07 = 0x03).
